// File: rtl/ula_flag_wb.sv
// Write-back stage behind the logic ALU: one-entry result register with valid/ready
// toward the register file, masked architectural flag register and branch-condition evaluation.
module ula_flag_wb #(
  parameter int bits   = 3,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [bits-1:0]   RESU,
  input  logic [4:0]        OP,
  input  logic [ADDR_W-1:0] DEST,
  input  logic              O_IN,
  input  logic              C_IN,
  input  logic              S_IN,
  input  logic              Z_IN,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [bits-1:0]   WB_DATA,
  output logic [ADDR_W-1:0] WB_ADDR,
  output logic [3:0]        FLAGS,
  input  logic [2:0]        COND,
  output logic              COND_TRUE
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [bits-1:0]   data_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [3:0]        flags_p1;
  logic              accept_p0;
  logic [3:0]        mask_p0;

  // Which of {O,C,S,Z} the producing opcode is allowed to overwrite.
  function automatic logic [3:0] flag_mask(input logic [4:0] op);
    logic [3:0] m;
    m = 4'b0000;
    if (op[4:3] == 2'b00) begin
      m = 4'b1111;
    end else begin
      case (op)
        5'b01000, 5'b01001: m = 4'b0111;
        5'b10000:           m = 4'b0001;
        5'b10011, 5'b11111: m = 4'b0000;
        default:            m = op[4] ? 4'b0011 : 4'b0000;
      endcase
    end
    return m;
  endfunction

  function automatic logic cond_eval(input logic [2:0] sel, input logic [3:0] f);
    logic r;
    case (sel)
      3'd0:    r = 1'b1;
      3'd1:    r = f[0];
      3'd2:    r = ~f[0];
      3'd3:    r = f[1];
      3'd4:    r = ~f[1];
      3'd5:    r = f[2];
      3'd6:    r = f[3];
      default: r = f[1] ^ f[3];
    endcase
    return r;
  endfunction

  assign OUT_VALID = (state_q == FULL);
  assign IN_READY  = !OUT_VALID || OUT_READY;
  assign accept_p0 = IN_VALID && IN_READY && !FLUSH;
  assign mask_p0   = flag_mask(OP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept_p0) state_d = FULL;
      FULL: begin
        if (FLUSH)          state_d = EMPTY;
        else if (accept_p0) state_d = FULL;
        else if (OUT_READY) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // p0 -> p1: result capture and masked flag merge on the accept edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_p1  <= '0;
      addr_p1  <= '0;
      flags_p1 <= 4'b0000;
    end else if (accept_p0) begin
      data_p1  <= RESU;
      addr_p1  <= DEST;
      flags_p1 <= (flags_p1 & ~mask_p0) | ({O_IN, C_IN, S_IN, Z_IN} & mask_p0);
    end
  end

  assign WB_DATA   = data_p1;
  assign WB_ADDR   = addr_p1;
  assign FLAGS     = flags_p1;
  assign COND_TRUE = cond_eval(COND, flags_p1);

endmodule

// File: tb/tb_ula_flag_wb.sv
// Randomized scoreboard bench for ula_flag_wb: a reference model queues expected write-backs
// and flag state at each clock edge; an independent monitor checks the DUT mid-cycle.
module tb_ula_flag_wb;
  localparam int BITS = 3;
  localparam int AW   = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            IN_VALID, IN_READY;
  logic [BITS-1:0] RESU;
  logic [4:0]      OP;
  logic [AW-1:0]   DEST;
  logic            O_IN, C_IN, S_IN, Z_IN;
  logic            FLUSH;
  logic            OUT_VALID, OUT_READY;
  logic [BITS-1:0] WB_DATA;
  logic [AW-1:0]   WB_ADDR;
  logic [3:0]      FLAGS;
  logic [2:0]      COND;
  logic            COND_TRUE;

  ula_flag_wb #(.bits(BITS), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .RESU(RESU), .OP(OP), .DEST(DEST), .O_IN(O_IN), .C_IN(C_IN), .S_IN(S_IN),
    .Z_IN(Z_IN), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .WB_DATA(WB_DATA), .WB_ADDR(WB_ADDR), .FLAGS(FLAGS), .COND(COND),
    .COND_TRUE(COND_TRUE)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [BITS-1:0] data; logic [AW-1:0] addr; } wb_t;
  wb_t exp_q[$];
  bit  m_full = 0;
  bit  m_o = 0, m_c = 0, m_s = 0, m_z = 0;
  bit  m_started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit ref_cond(input int sel, input bit o, input bit c, input bit s, input bit z);
    case (sel)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return s;
      4: return !s;
      5: return c;
      6: return o;
      default: return s ^ o;
    endcase
  endfunction

  // Reference model: evaluated at each rising edge from the rules of the stage.
  initial begin
    forever begin
      @(posedge clk);
      m_started = 1;
      if (!reset_n) begin
        exp_q.delete();
        m_full = 0;
        {m_o, m_c, m_s, m_z} = 4'b0000;
      end else begin
        bit rdy, acc;
        int k;
        wb_t e;
        rdy = !m_full || OUT_READY;
        acc = IN_VALID && rdy && !FLUSH;
        if (m_full && FLUSH && !OUT_READY && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
          e.data = RESU;
          e.addr = DEST;
          exp_q.push_back(e);
          k = OP;
          if (k < 8) begin
            m_o = O_IN; m_c = C_IN; m_s = S_IN; m_z = Z_IN;
          end else if (k == 8 || k == 9) begin
            m_c = C_IN; m_s = S_IN; m_z = Z_IN;
          end else if (k == 16) begin
            m_z = Z_IN;
          end else if (k == 19 || k == 31) begin
          end else if (k >= 17 && k <= 30) begin
            m_s = S_IN; m_z = Z_IN;
          end
        end
        m_full = acc ? 1'b1 : (FLUSH ? 1'b0 : (m_full && !OUT_READY));
      end
    end
  end

  // Monitor: mid-cycle, inputs and state are those the next edge will see.
  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        chk("out_valid", OUT_VALID, m_full);
        chk("in_ready", IN_READY, !m_full || OUT_READY);
        chk("flags", FLAGS, {m_o, m_c, m_s, m_z});
        chk("cond_true", COND_TRUE, ref_cond(COND, m_o, m_c, m_s, m_z));
        if (m_full) begin
          if (exp_q.size() == 0) begin
            chk("queue_underflow", 1, 0);
          end else begin
            chk("wb_data", WB_DATA, exp_q[0].data);
            chk("wb_addr", WB_ADDR, exp_q[0].addr);
            if (OUT_READY) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(input bit rn, input bit v, input logic [BITS-1:0] r, input logic [4:0] op,
                     input logic [AW-1:0] d, input logic [3:0] ocsz, input bit fl,
                     input bit ordy, input logic [2:0] cnd);
    reset_n = rn; IN_VALID = v; RESU = r; OP = op; DEST = d;
    {O_IN, C_IN, S_IN, Z_IN} = ocsz; FLUSH = fl; OUT_READY = ordy; COND = cnd;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cyc(input int p_ready, input int p_flush);
    cyc(1'b1, $urandom_range(0, 3) != 0, BITS'($urandom), 5'($urandom), AW'($urandom),
        4'($urandom), $urandom_range(0, 99) < p_flush, $urandom_range(0, 99) < p_ready,
        3'($urandom));
  endtask

  initial begin
    cyc(1'b0, 1'b1, 3'd7, 5'd0, 3'd7, 4'hF, 1'b0, 1'b1, 3'd0);
    cyc(1'b0, 1'b1, 3'd7, 5'd0, 3'd7, 4'hF, 1'b0, 1'b1, 3'd0);
    cyc(1'b1, 1'b0, 3'd0, 5'd0, 3'd0, 4'h0, 1'b0, 1'b1, 3'd0);
    chk("reset_wb_data", WB_DATA, 0);
    chk("reset_wb_addr", WB_ADDR, 0);
    chk("reset_flags", FLAGS, 0);

    // Logic op: only S,Z update
    cyc(1'b1, 1'b1, 3'b000, 5'b10001, 3'd5, 4'b1101, 1'b0, 1'b1, 3'd1);
    cyc(1'b1, 1'b0, 3'b000, 5'b10001, 3'd5, 4'b0000, 1'b0, 1'b1, 3'd1);
    chk("logic_flags", FLAGS, 4'b0001);
    chk("logic_addr", WB_ADDR, 5);
    // Shift then flag-neutral move
    cyc(1'b1, 1'b1, 3'b100, 5'b01000, 3'd2, 4'b0110, 1'b0, 1'b1, 3'd3);
    cyc(1'b1, 1'b1, 3'b011, 5'b10011, 3'd3, 4'b0000, 1'b0, 1'b1, 3'd3);
    cyc(1'b1, 1'b0, 3'b000, 5'b00000, 3'd0, 4'b0000, 1'b0, 1'b1, 3'd3);
    chk("move_flags", FLAGS, 4'b0110);
    // Backpressure
    cyc(1'b1, 1'b1, 3'b101, 5'b00000, 3'd4, 4'b1010, 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 3'b010, 5'b00000, 3'd6, 4'b0101, 1'b0, 1'b0, 3'd0);
    cyc(1'b1, 1'b1, 3'b010, 5'b00000, 3'd6, 4'b0101, 1'b0, 1'b1, 3'd0);
    // Flush with held result and incoming op
    cyc(1'b1, 1'b1, 3'b111, 5'b10001, 3'd1, 4'b1111, 1'b1, 1'b0, 3'd1);
    cyc(1'b1, 1'b0, 3'b000, 5'b00000, 3'd0, 4'b0000, 1'b0, 1'b0, 3'd1);
    // Throughput burst and COND sweep
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b1, BITS'(i), 5'($urandom), AW'(i), 4'($urandom), 1'b0, 1'b1, 3'(i));
    cyc(1'b1, 1'b1, 3'b001, 5'b00000, 3'd1, 4'b1010, 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 3'b000, 5'b00000, 3'd0, 4'b0000, 1'b0, 1'b1, 3'(i));
    // Reset overriding flush and handshake
    cyc(1'b1, 1'b1, 3'b110, 5'b00000, 3'd7, 4'b1111, 1'b0, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 3'b101, 5'b00000, 3'd5, 4'b1111, 1'b1, 1'b0, 3'd0);
    chk("rst2_wb_data", WB_DATA, 0);

    for (int i = 0; i < 600; i++) rand_cyc(75, 6);
    for (int i = 0; i < 300; i++) rand_cyc(25, 3);
    for (int i = 0; i < 300; i++) rand_cyc(100, 0);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b0, 3'b000, 5'b00000, 3'd0, 4'b0000, 1'b0, 1'b1, 3'd0);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
